// File: rtl/sudoku_mask_load.sv
// Sudoku candidate-exclusion mask loader: streams 81 cells and builds a 729-bit mask.
// Optional duplicate-given detection is built when SUDOKU_LOAD_CONFLICT_EN is defined.
module sudoku_mask_load (
    input  logic         clk,
    input  logic         rst,
    input  logic         cell_valid,
    output logic         cell_ready,
    input  logic [3:0]   cell_value,
    output logic         mask_valid,
    input  logic         mask_ready,
    output logic [728:0] puzzle_mask_bin,
    output logic         conflict,
    output logic         value_err
);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [3:0]   x_q, x_d;
    logic [3:0]   y_q, y_d;
    logic [728:0] mask_q, mask_d;
    logic [728:0] upd;
    logic         value_err_q, value_err_d;

    logic         take;
    logic         handoff;
    logic         last;
    logic         is_digit;
    logic         is_illegal;
    logic [3:0]   dig;
    logic [1:0]   bx, by;

    function automatic logic [1:0] box3(input logic [3:0] v);
        if (v < 4'd3) begin
            return 2'd0;
        end else if (v < 4'd6) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    assign take       = cell_valid && (state_q == S_LOAD);
    assign handoff    = mask_ready && (state_q == S_DONE);
    assign last       = (cnt_q == 7'd80);
    assign is_digit   = (cell_value != 4'd0) && (cell_value <= 4'd9);
    assign is_illegal = (cell_value >= 4'd10);
    assign dig        = cell_value - 4'd1;
    assign bx         = box3(x_q);
    assign by         = box3(y_q);

    // Per-transfer set vector: the cell excludes all other digits, peers exclude this one.
    always_comb begin
        upd = '0;
        if (take && is_digit) begin
            for (int i = 0; i < 9; i++) begin
                for (int j = 0; j < 9; j++) begin
                    for (int k = 0; k < 9; k++) begin
                        if ((4'(i) == x_q) && (4'(j) == y_q)) begin
                            upd[10'(i*81 + j*9 + k)] = (4'(k) != dig);
                        end else if ((4'(i) == x_q) || (4'(j) == y_q) ||
                                     ((box3(4'(i)) == bx) &&
                                      (box3(4'(j)) == by))) begin
                            upd[10'(i*81 + j*9 + k)] = (4'(k) == dig);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        mask_d      = mask_q;
        value_err_d = value_err_q;
        if (handoff) begin
            state_d     = S_LOAD;
            cnt_d       = 7'd0;
            x_d         = 4'd0;
            y_d         = 4'd0;
            mask_d      = '0;
            value_err_d = 1'b0;
        end else if (take) begin
            mask_d      = mask_q | upd;
            value_err_d = value_err_q | is_illegal;
            cnt_d       = cnt_q + 7'd1;
            if (y_q == 4'd8) begin
                y_d = 4'd0;
                x_d = x_q + 4'd1;
            end else begin
                y_d = y_q + 4'd1;
            end
            if (last) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= 7'd0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            mask_q      <= '0;
            value_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mask_q      <= mask_d;
            value_err_q <= value_err_d;
        end
    end

`ifdef SUDOKU_LOAD_CONFLICT_EN
    logic [9:0] own_idx;
    logic       conflict_q, conflict_d;

    // A given whose own bit is already excluded duplicates an earlier peer.
    assign own_idx = 10'(x_q) * 10'd81 + 10'(y_q) * 10'd9 + 10'(dig);

    always_comb begin
        conflict_d = conflict_q;
        if (handoff) begin
            conflict_d = 1'b0;
        end else if (take && is_digit && mask_q[own_idx]) begin
            conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;
`else
    assign conflict = 1'b0;
`endif

    assign cell_ready      = (state_q == S_LOAD);
    assign mask_valid      = (state_q == S_DONE);
    assign puzzle_mask_bin = mask_q;
    assign value_err       = value_err_q;

endmodule

// File: doc/sudoku_mask_load.md
SUDOKU_MASK_LOAD -- requirements
Module: sudoku_mask_load

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cell_valid  input  1  cell_value is presented.
REQ-005 cell_ready  output  1  the block accepts a cell this cycle.
REQ-006 cell_value  input  4  0 = empty; 1..9 = given digit; 10..15 = illegal.
REQ-007 mask_valid  output  1  puzzle_mask_bin is complete and stable.
REQ-008 mask_ready  input  1  downstream mask stage consumes the mask.
REQ-009 puzzle_mask_bin  output  729  candidate-exclusion mask. Bit x*81+y*9+d set means digit d+1 is impossible at column x, row y (x, y, d in 0..8).
REQ-010 conflict  output  1  the puzzle contains a duplicate given in a row, column or box; valid with mask_valid.
REQ-011 value_err  output  1  at least one illegal cell_value was accepted; valid with mask_valid.

Function
REQ-012 Cells SHALL arrive in order c = x*9+y, c = 0..80, one per accepted transfer (cell_valid & cell_ready); an internal 7-bit counter SHALL track c.
REQ-013 FSM states SHALL be LOAD and DONE; LOAD asserts cell_ready=1 and mask_valid=0; DONE asserts cell_ready=0 and mask_valid=1.
REQ-014 On accepting a digit d+1 at (x,y), the next cycle SHALL:
- set the cell's own bits x*81+y*9+k for all k != d;
- set bit d in every other cell of column x, row y and the 3x3 box (x/3, y/3);
- leave the cell's own bit d unchanged.
REQ-015 Accepted values 0 and 10..15 SHALL leave the mask unchanged; 10..15 SHALL additionally set value_err (sticky).
REQ-016 Mask bits SHALL only be set during LOAD, never cleared; updates from successive cells SHALL accumulate with no lost bits at one transfer per cycle.
REQ-017 Acceptance of cell c=80 SHALL move the FSM to DONE on the same edge that applies that cell's update, so mask_valid rises one cycle after the last transfer.
REQ-018 In DONE, puzzle_mask_bin, conflict and value_err SHALL hold stable until mask_valid & mask_ready.
REQ-019 On the handoff edge, the block SHALL clear the mask, conflict, value_err and counter to 0, return to LOAD, and raise cell_ready in the next cycle.
REQ-020 cell_valid while in DONE SHALL be ignored; mask_ready while in LOAD SHALL be ignored.
REQ-021 Output timing: all outputs SHALL be registered or decoded from FSM state only; there is no combinational path from any input to any output.

Reset
REQ-022 rst SHALL take priority over every other event, including a transfer or handoff in the same cycle.
REQ-023 Reset values SHALL be:
- state LOAD, counter 0;
- puzzle_mask_bin all 0;
- conflict 0, value_err 0, mask_valid 0;
- cell_ready 1 from the first cycle after rst deasserts.
REQ-024 Reset in the middle of a load SHALL discard the partial mask; the next accepted cell is c=0.

Configuration
REQ-025 Macro SUDOKU_LOAD_CONFLICT_EN: when defined, accepting digit d+1 at (x,y) whose own bit d is already 1 SHALL set conflict (sticky until handoff or reset).
REQ-026 When SUDOKU_LOAD_CONFLICT_EN is not defined, conflict SHALL be tied to 0 and no detection logic is built; the mask is identical in both builds.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- All 81 cells = 0, mask_ready=1 -> mask_valid high one cycle after c=80, mask all 0, conflict=0, value_err=0, cell_ready high again on the following cycle.
- Only c=0 = 5, rest 0 -> cell (0,0) bits {0,1,2,3,5,6,7,8} set; bit 4 set in cells (0,1..8), (1..8,0), (1,1),(1,2),(2,1),(2,2); every other bit 0.
- Digit 3 at c=0 and at c=40 (x=4,y=4) -> no conflict. Digit 3 at c=0 and at c=8 (same column) -> conflict=1 with CONFLICT_EN defined, 0 without.
- Cell value 12 at c=10 -> value_err=1 at mask_valid; mask matches the all-empty case for that cell.
- mask_ready held 0 for 20 cycles in DONE with cell_valid=1 -> mask stable, cell_ready=0, no cell consumed; handoff on release.
- rst at c=37 during a transfer -> mask all 0; a full 81-cell reload then produces the expected mask with no leftover bits.
